dt_feature_loader: RTL

Upstream feeder for the combinational decision-tree classifiers (e.g. `HeartDiseaseDT`). It accepts a byte-serial feature stream over a valid/ready handshake and assembles one 13-feature frame into a parallel register bank that drives the classifier inputs. One cycle after the frame completes, it captures the classifier's class output and presents it with a frame-error flag on a valid/ready result port. The block processes exactly one frame at a time; it never overlaps loading and result hold.

---
 rtl/dt_feature_loader_if.sv | 25 ++
 rtl/dt_feature_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/dt_feature_loader_if.sv
// Handshake bundle for dt_feature_loader: byte-serial feature stream in,
// classified result out. The loader takes the slave modport.
interface dt_feature_loader_if #(
  parameter int unsigned N = 8,
  parameter int unsigned C = 1
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [C-1:0] m_cls;
  logic         m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_cls, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_cls, m_err
  );
endinterface

// File: rtl/dt_feature_loader.sv
// Assembles a byte-serial feature frame into a parallel bank for a combinational
// decision-tree classifier and returns the captured class with a frame-error flag.
module dt_feature_loader #(
  parameter int unsigned N  = 8,
  parameter int unsigned NF = 13,
  parameter int unsigned C  = 1
) (
  input  logic                clk,
  input  logic                rst,
  dt_feature_loader_if.slave  bus,
  output logic [NF*N-1:0]     feat,
  input  logic [C-1:0]        cls_in,
  output logic [15:0]         frame_cnt
);
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {StLoad, StDrain, StEval, StHold} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [N-1:0]  slot_q [NF];
  logic          m_valid_q;
  logic          m_err_q;
  logic [C-1:0]  m_cls_q;
  logic [15:0]   cnt_q;

  logic s_fire;
  logic m_fire;
  logic at_end;

  // Ready is held low for the whole time reset is asserted.
  assign bus.s_ready = !rst && ((state_q == StLoad) || (state_q == StDrain));
  assign bus.m_valid = m_valid_q;
  assign bus.m_cls   = m_cls_q;
  assign bus.m_err   = m_err_q;
  assign frame_cnt   = cnt_q;

  assign s_fire = bus.s_valid && bus.s_ready;
  assign m_fire = m_valid_q && bus.m_ready;
  assign at_end = (idx_q == IW'(NF - 1));

  for (genvar k = 0; k < NF; k++) begin : g_pack
    assign feat[k*N +: N] = slot_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLoad;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_cls_q   <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < NF; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        StLoad: begin
          if (s_fire) begin
            slot_q[idx_q] <= bus.s_data;
            if (at_end) begin
              idx_q <= '0;
              if (bus.s_last) begin
                state_q <= StEval;
              end else begin
                // Long frame: swallow the excess bytes until the producer's last.
                state_q <= StDrain;
                m_err_q <= 1'b1;
              end
            end else if (bus.s_last) begin
              // Short frame: written slots stay, the rest keep old contents.
              idx_q     <= '0;
              state_q   <= StHold;
              m_err_q   <= 1'b1;
              m_cls_q   <= '0;
              m_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (s_fire && bus.s_last) begin
            state_q   <= StHold;
            m_err_q   <= 1'b1;
            m_cls_q   <= '0;
            m_valid_q <= 1'b1;
          end
        end
        StEval: begin
          state_q   <= StHold;
          m_cls_q   <= cls_in;
          m_err_q   <= 1'b0;
          m_valid_q <= 1'b1;
        end
        StHold: begin
          if (m_fire) begin
            state_q   <= StLoad;
            m_valid_q <= 1'b0;
            m_err_q   <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end
endmodule
